// File: rtl/crc16_rx_if.sv
// Bus between the bit un-stuffer / RX packet controller and the receive-side
// CRC16 checker: packet framing and bit strobes in, verdict and debug state out.
interface crc16_rx_if #(
    parameter int CNT_W = 11
);
    logic             clear;
    logic             pkt_start;
    logic             bit_in;
    logic             new_bit;
    logic             eop;
    logic             crc_busy;
    logic             crc_done;
    logic             crc_ok;
    logic             crc_err;
    logic             short_err;
    logic [15:0]      crc_reg;
    logic [CNT_W-1:0] bit_count;

    // Upstream side: drives framing and bits, observes the verdict.
    modport master (
        output clear, pkt_start, bit_in, new_bit, eop,
        input  crc_busy, crc_done, crc_ok, crc_err, short_err, crc_reg, bit_count
    );

    // Checker side.
    modport slave (
        input  clear, pkt_start, bit_in, new_bit, eop,
        output crc_busy, crc_done, crc_ok, crc_err, short_err, crc_reg, bit_count
    );
endinterface

// File: rtl/crc16_rx_checker.sv
// Receive-side CRC16 checker (x^16+x^15+x^2+1). Bits arrive LSB-first per byte
// over the data and CRC fields; at end of packet the LFSR is compared against
// the fixed residual and exactly one of ok / err / short is reported.
module crc16_rx_checker #(
    parameter logic [15:0] POLY     = 16'h8005,
    parameter logic [15:0] INIT     = 16'hFFFF,
    parameter logic [15:0] RESIDUAL = 16'h800D,
    parameter int          CNT_W    = 11
) (
    input  logic      clk,
    input  logic      n_rst,
    crc16_rx_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CNT_W-1:0] MIN_BITS = CNT_W'(16);

    logic [1:0]       state_reg;
    logic [15:0]      lfsr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             done_reg;
    logic             ok_reg;
    logic             err_reg;
    logic             short_reg;
    // Verdict captured at the end of CHECK, published out of DONE so that the
    // flags and the done pulse appear together two edges after eop.
    logic             verdict_ok_reg;
    logic             verdict_err_reg;
    logic             verdict_short_reg;

    logic             fb;
    logic [15:0]      lfsr_shift;

    // One LFSR step for the incoming bit (MSB-shift form, bit fed at the top).
    always_comb begin
        fb         = lfsr_reg[15] ^ bus.bit_in;
        lfsr_shift = {lfsr_reg[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end

    // Packet state machine, LFSR, bit counter and result flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg         <= IDLE;
            lfsr_reg          <= INIT;
            count_reg         <= '0;
            done_reg          <= 1'b0;
            ok_reg            <= 1'b0;
            err_reg           <= 1'b0;
            short_reg         <= 1'b0;
            verdict_ok_reg    <= 1'b0;
            verdict_err_reg   <= 1'b0;
            verdict_short_reg <= 1'b0;
        end else if (bus.clear) begin
            // Abort wins over everything, including a coincident pkt_start.
            state_reg         <= IDLE;
            lfsr_reg          <= INIT;
            count_reg         <= '0;
            done_reg          <= 1'b0;
            ok_reg            <= 1'b0;
            err_reg           <= 1'b0;
            short_reg         <= 1'b0;
            verdict_ok_reg    <= 1'b0;
            verdict_err_reg   <= 1'b0;
            verdict_short_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.pkt_start) begin
                        state_reg <= ACTIVE;
                        lfsr_reg  <= INIT;
                        count_reg <= '0;
                        ok_reg    <= 1'b0;
                        err_reg   <= 1'b0;
                        short_reg <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (bus.pkt_start) begin
                        // Restart: any bit strobed with the restart is dropped.
                        lfsr_reg  <= INIT;
                        count_reg <= '0;
                    end else begin
                        if (bus.new_bit) begin
                            lfsr_reg <= lfsr_shift;
                            if (count_reg != {CNT_W{1'b1}}) begin
                                count_reg <= count_reg + CNT_W'(1);
                            end
                        end
                        // A bit coincident with eop is absorbed before the check.
                        if (bus.eop) begin
                            state_reg <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    verdict_short_reg <= (count_reg < MIN_BITS);
                    verdict_ok_reg    <= (count_reg >= MIN_BITS) && (lfsr_reg == RESIDUAL);
                    verdict_err_reg   <= (count_reg >= MIN_BITS) && (lfsr_reg != RESIDUAL);
                    state_reg         <= DONE;
                end
                default: begin
                    if (bus.pkt_start) begin
                        // New packet immediately after the old one: drop the verdict.
                        state_reg <= ACTIVE;
                        lfsr_reg  <= INIT;
                        count_reg <= '0;
                        ok_reg    <= 1'b0;
                        err_reg   <= 1'b0;
                        short_reg <= 1'b0;
                    end else begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                        ok_reg    <= verdict_ok_reg;
                        err_reg   <= verdict_err_reg;
                        short_reg <= verdict_short_reg;
                    end
                end
            endcase
        end
    end

    assign bus.crc_busy  = (state_reg == ACTIVE) || (state_reg == CHECK);
    assign bus.crc_done  = done_reg;
    assign bus.crc_ok    = ok_reg;
    assign bus.crc_err   = err_reg;
    assign bus.short_err = short_reg;
    assign bus.crc_reg   = lfsr_reg;
    assign bus.bit_count = count_reg;

endmodule

// File: tb/tb_crc16_rx_checker.sv
// Directed bench for the receive-side CRC16 checker: good / corrupted / short
// packets, eop coincident with the last bit, clear, restart, async reset and
// bits while idle. Inputs change on negedge; outputs are sampled on negedge.
module tb_crc16_rx_checker;

    logic clk;
    logic n_rst;
    int   vectors;
    int   miscompares;
    logic [7:0] msg [9];

    crc16_rx_if #(.CNT_W(11)) bus ();

    crc16_rx_checker dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt();
        @(negedge clk);
        bus.pkt_start = 1'b1;
        @(negedge clk);
        bus.pkt_start = 1'b0;
    endtask

    // Back-to-back bits, LSB first; optionally raise eop with the last bit.
    task automatic send_bits(input logic [15:0] data, input int n, input logic eop_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.new_bit = 1'b1;
            bus.bit_in  = data[i];
            bus.eop     = eop_last && (i == n - 1);
        end
        @(negedge clk);
        bus.new_bit = 1'b0;
        bus.bit_in  = 1'b0;
        bus.eop     = 1'b0;
    endtask

    task automatic issue_eop();
        @(negedge clk);
        bus.eop = 1'b1;
        @(negedge clk);
        bus.eop = 1'b0;
    endtask

    // Called just after the edge that sampled eop (edge k).
    task automatic check_result(input string tag, input logic ok, input logic err,
                                input logic sht, input logic [31:0] cnt);
        check({tag, "_busy_check"}, {31'd0, bus.crc_busy}, 32'd1);
        check({tag, "_done_k"},     {31'd0, bus.crc_done}, 32'd0);
        @(negedge clk);
        check({tag, "_done_k1"},    {31'd0, bus.crc_done}, 32'd0);
        @(negedge clk);
        check({tag, "_done_k2"},    {31'd0, bus.crc_done}, 32'd1);
        check({tag, "_ok"},         {31'd0, bus.crc_ok},   {31'd0, ok});
        check({tag, "_err"},        {31'd0, bus.crc_err},  {31'd0, err});
        check({tag, "_short"},      {31'd0, bus.short_err},{31'd0, sht});
        check({tag, "_count"},      {21'd0, bus.bit_count}, cnt);
        check({tag, "_busy_idle"},  {31'd0, bus.crc_busy}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, bus.crc_done}, 32'd0);
        check({tag, "_ok_held"},    {31'd0, bus.crc_ok},   {31'd0, ok});
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        n_rst         = 1'b0;
        bus.clear     = 1'b0;
        bus.pkt_start = 1'b0;
        bus.bit_in    = 1'b0;
        bus.new_bit   = 1'b0;
        bus.eop       = 1'b0;
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_crc",   {16'd0, bus.crc_reg},   32'hFFFF);
        check("rst_count", {21'd0, bus.bit_count}, 32'd0);
        check("rst_flags", {27'd0, bus.crc_busy, bus.crc_done, bus.crc_ok, bus.crc_err, bus.short_err}, 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // Good packet: "123456789" then CRC 0xB4C8 (0xC8 first)
        start_pkt();
        check("good_busy", {31'd0, bus.crc_busy}, 32'd1);
        for (int i = 0; i < 9; i++) send_bits({8'h00, msg[i]}, 8, 1'b0);
        check("good_data_crc",   {16'd0, bus.crc_reg},   32'hECD2);
        check("good_data_count", {21'd0, bus.bit_count}, 32'd72);
        send_bits(16'h00C8, 8, 1'b0);
        send_bits(16'h00B4, 8, 1'b0);
        check("good_resid", {16'd0, bus.crc_reg}, 32'h800D);
        issue_eop();
        check_result("good", 1'b1, 1'b0, 1'b0, 32'd88);

        // Corrupted packet: bit 5 of byte 0 inverted
        start_pkt();
        check("corrupt_ok_cleared", {31'd0, bus.crc_ok}, 32'd0);
        send_bits(16'h0011, 8, 1'b0);
        for (int i = 1; i < 9; i++) send_bits({8'h00, msg[i]}, 8, 1'b0);
        send_bits(16'h00C8, 8, 1'b0);
        send_bits(16'h00B4, 8, 1'b0);
        issue_eop();
        check_result("corrupt", 1'b0, 1'b1, 1'b0, 32'd88);

        // eop together with the last CRC bit
        start_pkt();
        for (int i = 0; i < 9; i++) send_bits({8'h00, msg[i]}, 8, 1'b0);
        send_bits(16'h00C8, 8, 1'b0);
        send_bits(16'h00B4, 8, 1'b1);
        check_result("same_cycle", 1'b1, 1'b0, 1'b0, 32'd88);

        // Short packet: 10 bits
        start_pkt();
        send_bits(16'h03A5, 10, 1'b0);
        issue_eop();
        check_result("short", 1'b0, 1'b0, 1'b1, 32'd10);

        // clear after 30 bits, with a coincident pkt_start that must be ignored
        start_pkt();
        send_bits(16'hFFFF, 16, 1'b0);
        send_bits(16'h1234, 14, 1'b0);
        check("clear_pre_count", {21'd0, bus.bit_count}, 32'd30);
        @(negedge clk);
        bus.clear     = 1'b1;
        bus.pkt_start = 1'b1;
        @(negedge clk);
        bus.clear     = 1'b0;
        bus.pkt_start = 1'b0;
        check("clear_busy",  {31'd0, bus.crc_busy},  32'd0);
        check("clear_crc",   {16'd0, bus.crc_reg},   32'hFFFF);
        check("clear_count", {21'd0, bus.bit_count}, 32'd0);
        check("clear_short", {31'd0, bus.short_err}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("clear_no_done", {31'd0, bus.crc_done}, 32'd0);
        end

        // pkt_start mid-packet restarts; coincident bit is dropped
        start_pkt();
        send_bits(16'h5555, 16, 1'b0);
        send_bits(16'h000F, 4, 1'b0);
        @(negedge clk);
        bus.pkt_start = 1'b1;
        bus.new_bit   = 1'b1;
        bus.bit_in    = 1'b1;
        @(negedge clk);
        bus.pkt_start = 1'b0;
        bus.new_bit   = 1'b0;
        bus.bit_in    = 1'b0;
        check("restart_crc",   {16'd0, bus.crc_reg},   32'hFFFF);
        check("restart_count", {21'd0, bus.bit_count}, 32'd0);
        check("restart_busy",  {31'd0, bus.crc_busy},  32'd1);
        for (int i = 0; i < 9; i++) send_bits({8'h00, msg[i]}, 8, 1'b0);
        send_bits(16'h00C8, 8, 1'b0);
        send_bits(16'h00B4, 8, 1'b0);
        issue_eop();
        check_result("restart", 1'b1, 1'b0, 1'b0, 32'd88);

        // Async reset mid-packet
        start_pkt();
        send_bits(16'h0ABC, 12, 1'b0);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_crc",   {16'd0, bus.crc_reg},   32'hFFFF);
        check("arst_count", {21'd0, bus.bit_count}, 32'd0);
        check("arst_flags", {27'd0, bus.crc_busy, bus.crc_done, bus.crc_ok, bus.crc_err, bus.short_err}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", {31'd0, bus.crc_done}, 32'd0);
        end

        // Bits and eop while idle are ignored
        send_bits(16'hA5A5, 5, 1'b0);
        check("idle_crc",   {16'd0, bus.crc_reg},   32'hFFFF);
        check("idle_count", {21'd0, bus.bit_count}, 32'd0);
        issue_eop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_done", {30'd0, bus.crc_done, bus.crc_busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/crc16_rx_checker.md
Name: crc16_rx_checker

Overview:
- Receive-side CRC16 checker. It sits after the bit un-stuffer in the receiver module and before the RX packet controller.
- It consumes de-stuffed serial bits, LSB-first per byte, over the data field followed by the transmitted CRC field.
- At end-of-packet it compares the LFSR against the fixed USB residual and reports pass, fail, or short-packet.
- It is the counterpart of the transmit-side CRC calculator: same polynomial (x^16+x^15+x^2+1), opposite end of the link.

Parameters:
- POLY, 16'h8005: generator polynomial without the x^16 term.
- INIT, 16'hFFFF: LFSR value loaded at packet start.
- RESIDUAL, 16'h800D: required LFSR value after the data and CRC bits of a good packet.
- CNT_W, 11: width of the received-bit counter.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- n_rst  in  1  reset. Asynchronous, active-low.
- clear  in  1  synchronous abort. Forces IDLE and clears all results. Highest priority.
- pkt_start  in  1  single-cycle pulse: the first bit of a new packet follows.
- bit_in  in  1  de-stuffed data bit. Valid only when new_bit=1.
- new_bit  in  1  single-cycle strobe: bit_in is valid this cycle.
- eop  in  1  single-cycle pulse: end of packet, no further bits follow.
- crc_busy  out  1  high in ACTIVE and CHECK.
- crc_done  out  1  one-cycle pulse when the result outputs become valid.
- crc_ok  out  1  packet passed. Held until the next pkt_start or clear.
- crc_err  out  1  residual mismatch. Held until the next pkt_start or clear.
- short_err  out  1  fewer than 16 bits received before eop. Held until the next pkt_start or clear.
- crc_reg  out  16  current LFSR contents, for debug and the bench.
- bit_count  out  CNT_W  bits accepted in the current packet. Saturates at all-ones.

Behaviour:
- Reset values (n_rst=0): state=IDLE, crc_reg=INIT, bit_count=0, and crc_busy, crc_done, crc_ok, crc_err, short_err all 0.
- States: IDLE, ACTIVE, CHECK, DONE.
- IDLE:
  - pkt_start enters ACTIVE.
  - On entry to ACTIVE: crc_reg<=INIT, bit_count<=0, and crc_ok, crc_err, short_err all <=0.
  - new_bit and eop are ignored in IDLE.
- ACTIVE, on each new_bit=1:
  - fb = crc_reg[15]^bit_in
  - crc_reg <= {crc_reg[14:0],1'b0} ^ (fb ? POLY : 16'h0)
  - bit_count increments, saturating at all-ones.
- ACTIVE, on eop=1: go to CHECK.
  - If new_bit and eop are high in the same cycle, the bit is absorbed first and the check uses the updated crc_reg.
- ACTIVE, on pkt_start=1: restart. Reload INIT, zero bit_count, stay in ACTIVE. Any coincident new_bit is discarded.
- CHECK lasts one cycle, with no LFSR update. Outputs registered at its end:
  - bit_count<16: short_err<=1, crc_ok<=0, crc_err<=0.
  - else crc_reg==RESIDUAL: crc_ok<=1.
  - else: crc_err<=1.
  - Exactly one of crc_ok, crc_err, short_err is set per packet.
- DONE lasts one cycle: crc_done=1, then go to IDLE.
  - A pkt_start during DONE is honoured: go to ACTIVE and clear the results.
- Latency: eop sampled at edge k → results and crc_done visible after edge k+2. crc_done is high for exactly one cycle.
- clear=1 in any state: IDLE next edge, crc_reg<=INIT, bit_count<=0, all flags 0. Any coincident pkt_start is ignored.
- n_rst may assert mid-packet. Asynchronous return to reset values, no result pulse.
- Input rules:
  - new_bit may be high for at most one cycle per bit.
  - Back-to-back new_bit on consecutive cycles must be accepted.
  - crc_busy gives no backpressure: the block never stalls input.

Test Plan:
- Good packet: pkt_start; ASCII "123456789" (9 bytes, LSB-first) → crc_reg=16'hECD2 after 72 bits. Then send CRC 16'hB4C8 (0xC8 then 0xB4, LSB-first) and eop → crc_reg=16'h800D, bit_count=88, crc_ok=1 and crc_done pulses 2 edges after eop.
- Corrupted packet: same stimulus with bit 5 of byte 0 inverted → crc_err=1, crc_ok=0, single crc_done pulse.
- Short packet: pkt_start, 10 bits, eop → short_err=1, crc_ok=0, crc_err=0.
- new_bit and eop in the same cycle on the last CRC bit of the good packet → crc_ok=1, bit_count=88.
- Abort and restart:
  - clear mid-packet after 30 bits → IDLE next edge, crc_reg=16'hFFFF, no crc_done.
  - pkt_start mid-packet → restart. A subsequent full good packet passes.
- Async reset mid-packet and bits while IDLE:
  - n_rst low mid-packet → all outputs 0 immediately, crc_reg=16'hFFFF.
  - new_bit pulses while IDLE → crc_reg and bit_count unchanged.
